rv32_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the RV32I core. It sits beside the ALU, directly downstream of `register_file`. It consumes the `data1`/`data2` operands read for an M-extension instruction and produces the write-back triple (`rsW`, `rd`, `RegWEn`) that feeds the register file write port. It holds the core via `busy` for a fixed 34-cycle operation.

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/rv32_muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_rv32_muldiv_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension unit.
//   XLEN              : architectural register width
//   DIV_OVF_DIVIDEND  : most-negative dividend (signed overflow case)
//   muldiv_op_e       : M-extension op, encoded exactly as funct3
//   muldiv_state_e    : muldiv sequencer states
//   cneg32/cneg64     : conditional two's-complement negate helpers
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  // Negate v when n is set; with n = sign bit this yields the magnitude.
  function automatic logic [XLEN-1:0] cneg32(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg64(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Fixed 34-cycle latency from the
// accepting edge to the end of the done pulse, special cases included.
// Ports:
//   clk, rst          : clock, async active-high reset
//   start             : request (sampled in IDLE/DONE only)
//   funct3            : M-extension op select
//   data1, data2      : rs1 / rs2 operands (valid only in the start cycle)
//   rd_sel            : destination register index
//   busy              : high in CALC and FIX
//   done              : one-cycle result-valid pulse
//   rd, rsW, RegWEn   : register-file write-back data, index, enable
module rv32_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int REGF_WIDTH = 32,
  parameter int SELECTORS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [REGF_WIDTH-1:0] data1,
  input  logic [REGF_WIDTH-1:0] data2,
  input  logic [SELECTORS-1:0]  rd_sel,
  output logic                  busy,
  output logic                  done,
  output logic [REGF_WIDTH-1:0] rd,
  output logic [SELECTORS-1:0]  rsW,
  output logic                  RegWEn
);

  muldiv_state_e          state, state_nxt;
  muldiv_op_e             op, op_in;
  logic [4:0]             cnt;
  logic                   sign1, sign2;
  logic [XLEN-1:0]        a_raw;     // data1 as presented, for REM by zero
  logic [XLEN-1:0]        b_mag;     // divisor or multiplicand magnitude
  logic [2*XLEN-1:0]      acc;       // shared mul/div accumulator
  logic [SELECTORS-1:0]   sel_q;

  logic                   accept;
  logic                   s1_in, s2_in;
  logic [XLEN-1:0]        m1_in, m2_in;

  assign op_in  = muldiv_op_e'(funct3);
  assign accept = start && (state == IDLE || state == DONE);

  // Which operands are treated as signed for this op
  assign s1_in = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                 (op_in == OP_DIV)  || (op_in == OP_REM);
  assign s2_in = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign m1_in = cneg32(data1, s1_in && data1[XLEN-1]);
  assign m2_in = cneg32(data2, s2_in && data2[XLEN-1]);

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole 65-bit result right.
  logic [XLEN:0]          sum33;
  logic [2*XLEN-1:0]      mul_nxt;
  assign sum33   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_nxt = {sum33, acc[XLEN-1:1]};

  // Restoring divide step: upper half is the partial remainder, lower half
  // shifts dividend bits out at the top and quotient bits in at the bottom.
  logic [XLEN:0]          rem_sh;
  logic [XLEN-1:0]        diff;
  logic                   ge;
  logic [2*XLEN-1:0]      div_nxt;
  assign rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign ge      = rem_sh >= {1'b0, b_mag};
  // When ge holds the true difference is below b_mag, so 32 bits suffice.
  assign diff    = rem_sh[XLEN-1:0] - b_mag;
  assign div_nxt = {(ge ? diff : rem_sh[XLEN-1:0]), acc[XLEN-2:0], ge};

  // Sign fix-up and special cases
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        quo, rem, res;
  logic                   div0, ovf;
  assign prod = cneg64(acc, sign1 ^ sign2);
  assign quo  = cneg32(acc[XLEN-1:0], sign1 ^ sign2);
  assign rem  = cneg32(acc[2*XLEN-1:XLEN], sign1);
  assign div0 = (b_mag == '0);
  // sign2 is only ever set for signed ops, so sign2 && |b|==1 means b == -1
  assign ovf  = (a_raw == DIV_OVF_DIVIDEND) && sign2 && (b_mag == 32'd1);

  always_comb begin
    res = '0;
    case (op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = div0 ? '1 : (ovf ? DIV_OVF_DIVIDEND : quo);
      OP_REM, OP_REMU:              res = div0 ? a_raw : (ovf ? '0 : rem);
      default:                      res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= OP_MUL;
      cnt   <= '0;
      sign1 <= 1'b0;
      sign2 <= 1'b0;
      a_raw <= '0;
      b_mag <= '0;
      acc   <= '0;
      sel_q <= '0;
      rd    <= '0;
      rsW   <= '0;
    end else begin
      if (accept) begin
        op    <= op_in;
        cnt   <= '0;
        sign1 <= s1_in && data1[XLEN-1];
        sign2 <= s2_in && data2[XLEN-1];
        a_raw <= data1;
        sel_q <= rd_sel;
        if (funct3[2]) begin
          acc   <= {{XLEN{1'b0}}, m1_in};
          b_mag <= m2_in;
        end else begin
          acc   <= {{XLEN{1'b0}}, m2_in};
          b_mag <= m1_in;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 5'd1;
        acc <= op[2] ? div_nxt : mul_nxt;
      end else if (state == FIX) begin
        rd  <= res;
        rsW <= sel_q;
      end
    end
  end

  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign RegWEn = done && (rsW != '0);

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Self-checking bench for rv32_muldiv_unit: directed cases, timing, ignored
// start, reset abort, and randomized ops against an arithmetic reference.
module tb_rv32_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] data1, data2;
  logic [4:0]  rd_sel;
  logic        busy, done, RegWEn;
  logic [31:0] rd;
  logic [4:0]  rsW;

  int checks = 0;
  int errors = 0;

  rv32_muldiv_unit #(.REGF_WIDTH(32), .SELECTORS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .data1(data1), .data2(data2), .rd_sel(rd_sel),
    .busy(busy), .done(done), .rd(rd), .rsW(rsW), .RegWEn(RegWEn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; p = q; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; q = ua / ub; p = q; return p[31:0]; end
      3'd6: begin if (b == 0) return a; q = sa % sb; p = q; return p[31:0]; end
      default: begin if (b == 0) return a; q = ua % ub; p = q; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and follow it to done. inj != 0 pulses a foreign start at
  // edge E<inj>. Operands are scrambled after the accepting edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sel, input int inj);
    logic [31:0] exp;
    exp = ref_model(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; data1 = a; data2 = b; rd_sel = sel;
    @(posedge clk); #1;
    chk("accept_busy_done", {30'b0, busy, done}, 32'h2);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      start  = (i == inj);
      funct3 = 3'($urandom);
      data1  = $urandom;
      data2  = $urandom;
      rd_sel = 5'($urandom);
      @(posedge clk); #1;
      if (i < 33) chk($sformatf("busy_done_e%0d", i), {30'b0, busy, done}, 32'h2);
    end
    chk($sformatf("done_f%0d", f), {30'b0, busy, done}, 32'h1);
    chk($sformatf("rd_f%0d_%h_%h", f, a, b), rd, exp);
    chk("rsW", {27'b0, rsW}, {27'b0, sel});
    chk("RegWEn", {31'b0, RegWEn}, {31'b0, (sel != 5'd0)});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; funct3 = '0; data1 = '0; data2 = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_wen",  {31'b0, RegWEn}, 0);
    chk("rst_rd",   rd, 0);
    chk("rst_rsW",  {27'b0, rsW}, 0);
    @(negedge clk) rst = 1'b0;

    // directed results, including constants from hand calculation
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
    chk("mul_const", rd, 32'hFFFF_FFEB);
    idle(2);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    chk("mulh_const", rd, 32'h0);
    // back-to-back: next start lands in the DONE cycle
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
    chk("mulhu_const", rd, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 0);
    chk("mulhsu_const", rd, 32'hFFFF_FFFF);
    idle(1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    chk("div_const", rd, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
    chk("rem_const", rd, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 0);
    chk("divu_const", rd, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd10, 0);
    chk("remu_const", rd, 32'd2);
    run_op(3'd5, 32'd5, 32'd0, 5'd11, 0);
    chk("divu0_const", rd, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 5'd12, 0);
    chk("remu0_const", rd, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    chk("div_ovf_const", rd, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
    chk("rem_ovf_const", rd, 32'h0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd15, 0);
    chk("rem0_signed_const", rd, 32'hFFFF_FFF9);
    idle(1);
    // foreign start during CALC is ignored
    run_op(3'd0, 32'd1234, 32'd5678, 5'd16, 10);
    chk("inj_const", rd, 32'd7006652);
    idle(1);
    // rd_sel = 0 suppresses the write
    run_op(3'd0, 32'd6, 32'd7, 5'd0, 0);
    idle(1);
    run_op(3'd5, 32'd1000, 32'd3, 5'd17, 0);
    idle(1);

    // reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; data1 = 32'd999; data2 = 32'd7; rd_sel = 5'd18;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk) start = 1'b0;
      @(posedge clk);
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_wen",  {31'b0, RegWEn}, 0);
    chk("arst_rd",   rd, 0);
    chk("arst_rsW",  {27'b0, rsW}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("no_activity_after_rst", seen, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd19, 0);
    chk("mul_after_rst", rd, 32'd12);

    // randomized ops, random gaps (0 = back-to-back), random foreign starts
    for (int n = 0; n < 60; n++) begin
      int gap;
      run_op(3'($urandom), pick(), pick(), 5'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
